program_loader: RTL and testbench



---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader_uart_rx.sv | 96 +++++++++
 rtl/program_loader.sv | 132 +++++++++++++
 tb/tb_program_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants for the boot-time program loader.
// Holds FSM state encodings, UART constants and ROM sizing helpers.
package program_loader_pkg;

  localparam logic [2:0] LOADER_STATE_WAIT_LEN = 3'd0;
  localparam logic [2:0] LOADER_STATE_LOAD     = 3'd1;
  localparam logic [2:0] LOADER_STATE_CHECK    = 3'd2;
  localparam logic [2:0] LOADER_STATE_DONE     = 3'd3;
  localparam logic [2:0] LOADER_STATE_ERROR    = 3'd4;

  localparam int UART_DATA_BITS = 8;

  localparam logic [1:0] UART_STATE_IDLE  = 2'd0;
  localparam logic [1:0] UART_STATE_START = 2'd1;
  localparam logic [1:0] UART_STATE_DATA  = 2'd2;
  localparam logic [1:0] UART_STATE_STOP  = 2'd3;

  function automatic logic [31:0] rom_capacity(input int addr_bits);
    return 32'd1 << (addr_bits - 2);
  endfunction

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling,
// start-glitch rejection, one-cycle rx_valid / rx_ferr pulses.
module uart_rx
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [1:0]    sync;
  logic          rx_d;
  logic          rx_s;
  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= 2'b11;
      rx_d     <= 1'b1;
      st       <= UART_STATE_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_byte  <= '0;
    end else begin
      sync     <= {sync[0], rx};
      rx_d     <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      unique case (st)
        UART_STATE_IDLE: begin
          if (rx_d && !rx_s) begin
            st  <= UART_STATE_START;
            cnt <= '0;
          end
        end
        UART_STATE_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            // a line already high again mid start bit was a glitch
            st      <= rx_s ? UART_STATE_IDLE : UART_STATE_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UART_STATE_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == LAST_BIT) begin
              st <= UART_STATE_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UART_STATE_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            st  <= UART_STATE_IDLE;
            if (rx_s) begin
              rx_valid <= 1'b1;
              rx_byte  <= shift;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= UART_STATE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed image over UART into the ROM.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ          = 100000000,
  parameter int BAUD_RATE            = 115200,
  parameter int ROM_ADDRESS_BITWIDTH = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            uart_rx,
  output logic                            rom_wren,
  output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
  output logic [31:0]                     rom_write_data,
  output logic                            cpu_reset_n,
  output logic                            load_done,
  output logic                            load_error,
  output logic [ROM_ADDRESS_BITWIDTH-2:0] loaded_words
);

  localparam int AW = ROM_ADDRESS_BITWIDTH;
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [31:0] CAPACITY = rom_capacity(AW);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] LOADER_STATE_END = LOADER_STATE_CHECK;
`else
  localparam logic [2:0] LOADER_STATE_END = LOADER_STATE_DONE;
`endif

  logic        rx_valid;
  logic        rx_ferr;
  logic [7:0]  rx_byte;
  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  logic [31:0] shift;
  logic [31:0] word_count;
  logic [31:0] asm_word;
  logic [31:0] next_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk     (clk),
    .reset   (reset),
    .rx      (uart_rx),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte),
    .rx_ferr (rx_ferr)
  );

  // bytes arrive LSB first, so each one shifts in from the top
  assign asm_word   = {rx_byte, shift[31:8]};
  assign next_count = 32'(loaded_words) + 32'd1;

  assign load_done   = (state == LOADER_STATE_DONE);
  assign cpu_reset_n = (state == LOADER_STATE_DONE);
  assign load_error  = (state == LOADER_STATE_ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= LOADER_STATE_WAIT_LEN;
      byte_cnt       <= '0;
      shift          <= '0;
      word_count     <= '0;
      rom_wren       <= 1'b0;
      rom_address    <= '0;
      rom_write_data <= '0;
      loaded_words   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      rom_wren <= 1'b0;
      unique case (state)
        LOADER_STATE_WAIT_LEN: begin
          if (rx_ferr) begin
            state <= LOADER_STATE_ERROR;
          end else if (rx_valid) begin
            shift    <= asm_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              word_count <= asm_word;
              if (asm_word > CAPACITY)
                state <= LOADER_STATE_ERROR;
              else if (asm_word == 32'd0)
                state <= LOADER_STATE_END;
              else
                state <= LOADER_STATE_LOAD;
            end
          end
        end
        LOADER_STATE_LOAD: begin
          if (rx_ferr) begin
            state <= LOADER_STATE_ERROR;
          end else if (rx_valid) begin
            shift    <= asm_word;
            byte_cnt <= byte_cnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_byte;
`endif
            if (byte_cnt == 2'd3) begin
              rom_wren       <= 1'b1;
              rom_address    <= {loaded_words[AW-3:0], 2'b00};
              rom_write_data <= asm_word;
              loaded_words   <= loaded_words + 1'b1;
              if (next_count == word_count)
                state <= LOADER_STATE_END;
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        LOADER_STATE_CHECK: begin
          if (rx_ferr)
            state <= LOADER_STATE_ERROR;
          else if (rx_valid)
            state <= (rx_byte == csum) ? LOADER_STATE_DONE
                                       : LOADER_STATE_ERROR;
        end
`endif
        LOADER_STATE_DONE:  state <= LOADER_STATE_DONE;
        LOADER_STATE_ERROR: state <= LOADER_STATE_ERROR;
        default:            state <= LOADER_STATE_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: 16 clks/bit, 16-word ROM.
// Covers normal, oversize, full-capacity, glitch, framing and reset loads.
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       uart_rx;
  logic       rom_wren;
  logic [5:0] rom_address;
  logic [31:0] rom_write_data;
  logic       cpu_reset_n;
  logic       load_done;
  logic       load_error;
  logic [4:0] loaded_words;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int base;

  program_loader #(
    .CLK_FREQ_HZ         (16),
    .BAUD_RATE           (1),
    .ROM_ADDRESS_BITWIDTH(6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .rom_wren      (rom_wren),
    .rom_address   (rom_address),
    .rom_write_data(rom_write_data),
    .cpu_reset_n   (cpu_reset_n),
    .load_done     (load_done),
    .load_error    (load_error),
    .loaded_words  (loaded_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rom_wren === 1'b1) begin
      wr_addr[wr_cnt[5:0]] = 32'(rom_address);
      wr_data[wr_cnt[5:0]] = rom_write_data;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stop;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    frame(b, 1'b1);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_image2;
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h90);
`endif
    repeat (8) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wren", 32'(rom_wren), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    chk("rst_cpu", 32'(cpu_reset_n), 32'd0);
    chk("rst_words", 32'(loaded_words), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // two-word image
    base = wr_cnt;
    send_image2();
    chk("img_nwr", 32'(wr_cnt - base), 32'd2);
    chk("img_a0", wr_addr[base[5:0]], 32'h00);
    chk("img_d0", wr_data[base[5:0]], 32'h00000013);
    chk("img_a1", wr_addr[6'(base + 1)], 32'h04);
    chk("img_d1", wr_data[6'(base + 1)], 32'h00100093);
    chk("img_done", 32'(load_done), 32'd1);
    chk("img_cpu", 32'(cpu_reset_n), 32'd1);
    chk("img_words", 32'(loaded_words), 32'd2);
    chk("img_err", 32'(load_error), 32'd0);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    repeat (8) @(negedge clk);
    chk("done_ignore", 32'(wr_cnt - base), 32'd2);

    // oversize length
    do_reset();
    base = wr_cnt;
    send(8'h11); send(8'h00); send(8'h00); send(8'h00);
    repeat (4) @(negedge clk);
    chk("big_err", 32'(load_error), 32'd1);
    chk("big_cpu", 32'(cpu_reset_n), 32'd0);
    chk("big_nwr", 32'(wr_cnt - base), 32'd0);

    // exactly full capacity
    do_reset();
    base = wr_cnt;
    send(8'h10); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 16; i++) begin
      send(8'(i)); send(8'h5A); send(8'hA5); send(8'(i));
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    repeat (8) @(negedge clk);
    chk("cap_nwr", 32'(wr_cnt - base), 32'd16);
    chk("cap_alast", wr_addr[6'(base + 15)], 32'h3C);
    chk("cap_dlast", wr_data[6'(base + 15)], 32'h0FA55A0F);
    chk("cap_words", 32'(loaded_words), 32'd16);
    chk("cap_done", 32'(load_done), 32'd1);

    // start-bit glitch then a one-word load
    do_reset();
    base = wr_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    repeat (8) @(negedge clk);
    chk("gl_nwr", 32'(wr_cnt - base), 32'd1);
    chk("gl_d0", wr_data[base[5:0]], 32'hDDCCBBAA);
    chk("gl_done", 32'(load_done), 32'd1);

    // zero-length image
    do_reset();
    base = wr_cnt;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    repeat (8) @(negedge clk);
    chk("zero_done", 32'(load_done), 32'd1);
    chk("zero_nwr", 32'(wr_cnt - base), 32'd0);

    // framing error inside a word
    do_reset();
    base = wr_cnt;
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33);
    frame(8'h44, 1'b0);
    repeat (8) @(negedge clk);
    chk("fe_err", 32'(load_error), 32'd1);
    chk("fe_nwr", 32'(wr_cnt - base), 32'd0);
    chk("fe_cpu", 32'(cpu_reset_n), 32'd0);

    // reset after one word, then a full reload
    do_reset();
    base = wr_cnt;
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    repeat (4) @(negedge clk);
    chk("mid_words", 32'(loaded_words), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_cpu", 32'(cpu_reset_n), 32'd0);
    chk("mid_rst_words", 32'(loaded_words), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_image2();
    chk("mid_words2", 32'(loaded_words), 32'd2);
    chk("mid_done", 32'(load_done), 32'd1);
    chk("mid_cpu", 32'(cpu_reset_n), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // wrong checksum after a one-word image
    do_reset();
    base = wr_cnt;
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h14);
    repeat (8) @(negedge clk);
    chk("cs_nwr", 32'(wr_cnt - base), 32'd1);
    chk("cs_err", 32'(load_error), 32'd1);
    chk("cs_cpu", 32'(cpu_reset_n), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
